// File: rtl/sys_pkg.sv
// Shared constants and FSM state encoding for the UART command sequencer.
package sys_pkg;

    localparam int unsigned OPCODE_W  = 8;
    localparam int unsigned ALU_FUN_W = 4;

    localparam logic [OPCODE_W-1:0] CMD_WR      = 8'hAA;
    localparam logic [OPCODE_W-1:0] CMD_RD      = 8'hBB;
    localparam logic [OPCODE_W-1:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [OPCODE_W-1:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [OPCODE_W-1:0] ERR_BYTE    = 8'hEE;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        FUN,
        ALU_EN,
        ALU_WAIT,
        PUSH,
        PUSH_HI
    } state_t;

endpackage

// File: rtl/cmd_sequencer_if.sv
// Bundles the sequencer's UART-in, register-file, ALU and TX-FIFO signals.
//   master : the sequencer (drives rf_*, alu_fun/alu_en/clk_gate_en, fifo_wr_*)
//   slave  : the surrounding system (drives rx_*, rf_rd_*, alu_out*, fifo_full)
interface cmd_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    import sys_pkg::*;

    logic [DATA_W-1:0]    rx_p_data;
    logic                 rx_d_valid;

    logic [ADDR_W-1:0]    rf_addr;
    logic [DATA_W-1:0]    rf_wr_data;
    logic                 rf_wr_en;
    logic                 rf_rd_en;
    logic [DATA_W-1:0]    rf_rd_data;
    logic                 rf_rd_valid;

    logic [ALU_FUN_W-1:0] alu_fun;
    logic                 alu_en;
    logic                 clk_gate_en;
    logic [2*DATA_W-1:0]  alu_out;
    logic                 alu_out_valid;

    logic [DATA_W-1:0]    fifo_wr_data;
    logic                 fifo_wr_inc;
    logic                 fifo_full;

    modport master (
        input  rx_p_data, rx_d_valid, rf_rd_data, rf_rd_valid,
               alu_out, alu_out_valid, fifo_full,
        output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
               alu_fun, alu_en, clk_gate_en, fifo_wr_data, fifo_wr_inc
    );

    modport slave (
        output rx_p_data, rx_d_valid, rf_rd_data, rf_rd_valid,
               alu_out, alu_out_valid, fifo_full,
        input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
               alu_fun, alu_en, clk_gate_en, fifo_wr_data, fifo_wr_inc
    );

endinterface

// File: rtl/cmd_sequencer.sv
// Decodes UART command frames into register-file writes/reads and ALU runs,
// and pushes read data, ALU results or a timeout error byte to the TX FIFO.
//   ref_clk : sole clock
//   rst     : synchronous active-high reset
//   bus     : cmd_sequencer_if master (UART in, RF, ALU, TX FIFO)
module cmd_sequencer
    import sys_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             ref_clk,
    input  logic             rst,
    cmd_sequencer_if.master  bus
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    push_lo_q, push_lo_d;
    logic [DATA_W-1:0]    push_hi_q, push_hi_d;
    logic                 push_two_q, push_two_d;

    logic [ADDR_W-1:0]    rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]    rf_wr_data_q, rf_wr_data_d;
    logic                 rf_wr_en_q, rf_wr_en_d;
    logic                 rf_rd_en_q, rf_rd_en_d;
    logic [ALU_FUN_W-1:0] alu_fun_q, alu_fun_d;
    logic                 alu_en_q, alu_en_d;
    logic                 clk_gate_en_q, clk_gate_en_d;
    logic [DATA_W-1:0]    fifo_wr_data_q, fifo_wr_data_d;
    logic                 fifo_wr_inc_q, fifo_wr_inc_d;

    logic                 timed_out;

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and registered outputs
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            push_lo_q      <= '0;
            push_hi_q      <= '0;
            push_two_q     <= 1'b0;
            rf_addr_q      <= '0;
            rf_wr_data_q   <= '0;
            rf_wr_en_q     <= 1'b0;
            rf_rd_en_q     <= 1'b0;
            alu_fun_q      <= '0;
            alu_en_q       <= 1'b0;
            clk_gate_en_q  <= 1'b0;
            fifo_wr_data_q <= '0;
            fifo_wr_inc_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            push_lo_q      <= push_lo_d;
            push_hi_q      <= push_hi_d;
            push_two_q     <= push_two_d;
            rf_addr_q      <= rf_addr_d;
            rf_wr_data_q   <= rf_wr_data_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rf_rd_en_q     <= rf_rd_en_d;
            alu_fun_q      <= alu_fun_d;
            alu_en_q       <= alu_en_d;
            clk_gate_en_q  <= clk_gate_en_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            fifo_wr_inc_q  <= fifo_wr_inc_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        push_lo_d      = push_lo_q;
        push_hi_d      = push_hi_q;
        push_two_d     = push_two_q;
        rf_addr_d      = rf_addr_q;
        rf_wr_data_d   = rf_wr_data_q;
        rf_wr_en_d     = 1'b0;
        rf_rd_en_d     = 1'b0;
        alu_fun_d      = alu_fun_q;
        alu_en_d       = 1'b0;
        clk_gate_en_d  = clk_gate_en_q;
        fifo_wr_data_d = fifo_wr_data_q;
        fifo_wr_inc_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_d_valid) begin
                    if (bus.rx_p_data == DATA_W'(CMD_WR))           state_d = WR_ADDR;
                    else if (bus.rx_p_data == DATA_W'(CMD_RD))      state_d = RD_ADDR;
                    else if (bus.rx_p_data == DATA_W'(CMD_ALU_OP))  state_d = OPA;
                    else if (bus.rx_p_data == DATA_W'(CMD_ALU_NOP)) state_d = FUN;
                end
            end
            WR_ADDR: begin
                if (bus.rx_d_valid) begin
                    rf_addr_d = ADDR_W'(bus.rx_p_data);
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.rx_d_valid) begin
                    rf_wr_data_d = bus.rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.rx_d_valid) begin
                    rf_addr_d  = ADDR_W'(bus.rx_p_data);
                    rf_rd_en_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.rf_rd_valid) begin
                    push_lo_d  = bus.rf_rd_data;
                    push_two_d = 1'b0;
                    state_d    = PUSH;
                end else if (timed_out) begin
                    push_lo_d  = DATA_W'(ERR_BYTE);
                    push_two_d = 1'b0;
                    state_d    = PUSH;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            OPA: begin
                if (bus.rx_d_valid) begin
                    rf_addr_d    = ADDR_W'(OPA_ADDR);
                    rf_wr_data_d = bus.rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = OPB;
                end
            end
            OPB: begin
                if (bus.rx_d_valid) begin
                    rf_addr_d    = ADDR_W'(OPB_ADDR);
                    rf_wr_data_d = bus.rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = FUN;
                end
            end
            FUN: begin
                if (bus.rx_d_valid) begin
                    alu_fun_d     = ALU_FUN_W'(bus.rx_p_data);
                    clk_gate_en_d = 1'b1;
                    state_d       = ALU_EN;
                end
            end
            // Clock gate is already open here, so alu_en trails it by one cycle
            ALU_EN: begin
                alu_en_d = 1'b1;
                cnt_d    = '0;
                state_d  = ALU_WAIT;
            end
            ALU_WAIT: begin
                if (bus.alu_out_valid) begin
                    push_lo_d     = bus.alu_out[DATA_W-1:0];
                    push_hi_d     = bus.alu_out[2*DATA_W-1:DATA_W];
                    push_two_d    = 1'b1;
                    clk_gate_en_d = 1'b0;
                    state_d       = PUSH;
                end else if (timed_out) begin
                    push_lo_d     = DATA_W'(ERR_BYTE);
                    push_two_d    = 1'b0;
                    clk_gate_en_d = 1'b0;
                    state_d       = PUSH;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            PUSH: begin
                if (!bus.fifo_full) begin
                    fifo_wr_data_d = push_lo_q;
                    fifo_wr_inc_d  = 1'b1;
                    state_d        = push_two_q ? PUSH_HI : IDLE;
                end
            end
            // Wait for the low-byte pulse to retire so fifo_full reflects it
            PUSH_HI: begin
                if (!bus.fifo_full && !fifo_wr_inc_q) begin
                    fifo_wr_data_d = push_hi_q;
                    fifo_wr_inc_d  = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rf_addr      = rf_addr_q;
    assign bus.rf_wr_data   = rf_wr_data_q;
    assign bus.rf_wr_en     = rf_wr_en_q;
    assign bus.rf_rd_en     = rf_rd_en_q;
    assign bus.alu_fun      = alu_fun_q;
    assign bus.alu_en       = alu_en_q;
    assign bus.clk_gate_en  = clk_gate_en_q;
    assign bus.fifo_wr_data = fifo_wr_data_q;
    assign bus.fifo_wr_inc  = fifo_wr_inc_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed and randomised frames against a frame-level model of the sequencer.
module tb_cmd_sequencer;
    import sys_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .ref_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed transactions
    logic [11:0] wr_q[$];
    logic [7:0]  push_q[$];
    int          rd_cnt = 0, alu_en_cnt = 0;
    logic [3:0]  last_rd_addr = '0;
    int          rd_cyc = 0, push_cyc = 0, gate_rise_cyc = 0, alu_en_cyc = 0;
    int          dbl = 0, full_viol = 0;
    logic        prev_wr = 0, prev_rd = 0, prev_alu = 0, prev_inc = 0, prev_gate = 0;
    logic [7:0]  env_rf   [16];
    logic [7:0]  model_rf [16];

    // Monitor: also acts as the register file the sequencer writes into
    always @(negedge clk) begin
        if (bus.rf_wr_en) begin
            wr_q.push_back({bus.rf_addr, bus.rf_wr_data});
            env_rf[bus.rf_addr] = bus.rf_wr_data;
        end
        if (bus.rf_rd_en) begin
            rd_cnt++;
            last_rd_addr = bus.rf_addr;
            rd_cyc = cyc;
        end
        if (bus.fifo_wr_inc) begin
            push_q.push_back(bus.fifo_wr_data);
            push_cyc = cyc;
            if (bus.fifo_full) full_viol++;
        end
        if (bus.alu_en) begin
            alu_en_cnt++;
            alu_en_cyc = cyc;
        end
        if (bus.clk_gate_en && !prev_gate) gate_rise_cyc = cyc;
        if ((bus.rf_wr_en && prev_wr) || (bus.rf_rd_en && prev_rd) ||
            (bus.alu_en && prev_alu) || (bus.fifo_wr_inc && prev_inc)) dbl++;
        prev_wr   = bus.rf_wr_en;
        prev_rd   = bus.rf_rd_en;
        prev_alu  = bus.alu_en;
        prev_inc  = bus.fifo_wr_inc;
        prev_gate = bus.clk_gate_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_p_data  = b;
        bus.rx_d_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_d_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    function automatic int cnt_of(input int sel);
        case (sel)
            0:       return wr_q.size();
            1:       return rd_cnt;
            2:       return push_q.size();
            3:       return alu_en_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
        int t;
        t = 0;
        while (cnt_of(sel) < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_arrived"}, 32'(cnt_of(sel) >= target), 32'd1);
    endtask

    task automatic clear_obs();
        wr_q.delete();
        push_q.delete();
    endtask

    function automatic logic [11:0] wr_ent(input logic [7:0] a, input logic [7:0] d);
        logic [3:0] a4;
        a4 = a[3:0];
        return {a4, d};
    endfunction

    // RF read frame: returns data from the monitor's RF after dly cycles
    task automatic do_read(input string tag, input logic [7:0] a, input int dly, input bit spur);
        int base;
        base = rd_cnt;
        clear_obs();
        send_byte(CMD_RD);
        send_byte(a);
        wait_cnt({tag, "_rd_en"}, 1, base + 1, 20);
        chk({tag, "_rd_addr"}, 32'(last_rd_addr), 32'(a[3:0]));
        if (spur) begin
            send_byte(CMD_WR);
            dly = (dly > 3) ? dly - 3 : 0;
        end
        tick(dly);
        bus.rf_rd_data  = env_rf[last_rd_addr];
        bus.rf_rd_valid = 1'b1;
        tick(1);
        bus.rf_rd_valid = 1'b0;
        wait_cnt({tag, "_push"}, 2, 1, 10);
        tick(3);
        chk({tag, "_npush"}, 32'(push_q.size()), 32'd1);
        if (push_q.size() > 0) chk({tag, "_data"}, 32'(push_q[0]), 32'(model_rf[a[3:0]]));
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
        clear_obs();
        send_byte(CMD_WR);
        send_byte(a);
        send_byte(d);
        model_rf[a[3:0]] = d;
        tick(4);
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) chk({tag, "_wr"}, 32'(wr_q[0]), 32'(wr_ent(a, d)));
        chk({tag, "_npush"}, 32'(push_q.size()), 32'd0);
    endtask

    // ALU frame with (op=1) or without (op=0) operand bytes
    task automatic do_alu(input string tag, input bit op, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] f, input logic [15:0] res, input int dly, input int full_cycles);
        int base;
        base = alu_en_cnt;
        clear_obs();
        send_byte(op ? CMD_ALU_OP : CMD_ALU_NOP);
        if (op) begin
            send_byte(x);
            send_byte(y);
            model_rf[0] = x;
            model_rf[1] = y;
        end
        send_byte(f);
        wait_cnt({tag, "_alu_en"}, 3, base + 1, 20);
        chk({tag, "_fun"}, 32'(bus.alu_fun), 32'(f[3:0]));
        chk({tag, "_gate_lead"}, 32'(alu_en_cyc - gate_rise_cyc), 32'd1);
        if (full_cycles > 0) bus.fifo_full = 1'b1;
        tick(dly);
        bus.alu_out       = res;
        bus.alu_out_valid = 1'b1;
        tick(1);
        bus.alu_out_valid = 1'b0;
        if (full_cycles > 0) begin
            tick(full_cycles);
            chk({tag, "_held_full"}, 32'(push_q.size()), 32'd0);
            bus.fifo_full = 1'b0;
        end
        wait_cnt({tag, "_push"}, 2, 2, 12);
        tick(3);
        chk({tag, "_npush"}, 32'(push_q.size()), 32'd2);
        if (push_q.size() >= 2) begin
            chk({tag, "_lsb"}, 32'(push_q[0]), 32'(res[7:0]));
            chk({tag, "_msb"}, 32'(push_q[1]), 32'(res[15:8]));
        end
        chk({tag, "_gate_off"}, 32'(bus.clk_gate_en), 32'd0);
        chk({tag, "_nwr"}, 32'(wr_q.size()), op ? 32'd2 : 32'd0);
        if (op && wr_q.size() >= 2) begin
            chk({tag, "_wr_a"}, 32'(wr_q[0]), 32'(wr_ent(8'h00, x)));
            chk({tag, "_wr_b"}, 32'(wr_q[1]), 32'(wr_ent(8'h01, y)));
        end
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d, x, y, f, jb;
        logic [15:0] res;
        int lat, kind;

        bus.rx_p_data     = '0;
        bus.rx_d_valid    = 1'b0;
        bus.rf_rd_data    = '0;
        bus.rf_rd_valid   = 1'b0;
        bus.alu_out       = '0;
        bus.alu_out_valid = 1'b0;
        bus.fifo_full     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            env_rf[i]   = '0;
            model_rf[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en",   32'(bus.rf_wr_en),     32'd0);
        chk("rst_rd_en",   32'(bus.rf_rd_en),     32'd0);
        chk("rst_alu_en",  32'(bus.alu_en),       32'd0);
        chk("rst_gate",    32'(bus.clk_gate_en),  32'd0);
        chk("rst_inc",     32'(bus.fifo_wr_inc),  32'd0);
        chk("rst_addr",    32'(bus.rf_addr),      32'd0);
        chk("rst_wdata",   32'(bus.rf_wr_data),   32'd0);
        chk("rst_fun",     32'(bus.alu_fun),      32'd0);
        chk("rst_fdata",   32'(bus.fifo_wr_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        do_write("wr_08", 8'h08, 8'hDD);
        do_read("rd_08", 8'h08, 3, 1'b0);
        do_alu("alu_cc", 1'b1, 8'h08, 8'h02, 8'h01, 16'h0006, 2, 0);
        do_alu("alu_dd_full", 1'b0, 8'h00, 8'h00, 8'h0D, 16'hA55A, 1, 10);
        do_read("rd_opa_kept", 8'h00, 2, 1'b0);

        // Read with no response: timeout pushes the error byte
        clear_obs();
        send_byte(CMD_RD);
        send_byte(8'h03);
        wait_cnt("to_push", 2, 1, TO + 20);
        lat = push_cyc - rd_cyc;
        chk("to_data", 32'(push_q.size() > 0 ? push_q[0] : 8'h00), 32'(ERR_BYTE));
        chk("to_latency", 32'(lat >= int'(TO) && lat <= int'(TO) + 2), 32'd1);
        tick(4);
        chk("to_once", 32'(push_q.size()), 32'd1);
        clear_obs();
        send_byte(8'h55);
        tick(4);
        chk("junk_55_nwr", 32'(wr_q.size()), 32'd0);
        chk("junk_55_npush", 32'(push_q.size()), 32'd0);
        do_write("after_to", 8'h13, 8'h5A);

        // Reset in the middle of a write frame
        clear_obs();
        send_byte(CMD_WR);
        send_byte(8'h05);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send_byte(8'h77);
        tick(4);
        chk("midrst_nwr", 32'(wr_q.size()), 32'd0);
        chk("midrst_npush", 32'(push_q.size()), 32'd0);
        do_write("after_rst", 8'h02, 8'h44);

        // Randomised frames
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            a = 8'($urandom);
            d = 8'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            f = 8'($urandom);
            res = 16'($urandom);
            case (kind)
                0: do_write("r_wr", a, d);
                1: do_read("r_rd", a, $urandom_range(4, 8), 1'($urandom_range(0, 1)));
                2: do_alu("r_cc", 1'b1, x, y, f, res, $urandom_range(1, 6), 0);
                3: do_alu("r_dd", 1'b0, x, y, f, res, $urandom_range(1, 6), $urandom_range(0, 3));
                default: begin
                    jb = 8'($urandom);
                    if (jb == CMD_WR || jb == CMD_RD || jb == CMD_ALU_OP || jb == CMD_ALU_NOP)
                        jb = 8'h11;
                    clear_obs();
                    send_byte(jb);
                    bus.rf_rd_valid   = 1'b1;
                    bus.alu_out_valid = 1'b1;
                    tick(1);
                    bus.rf_rd_valid   = 1'b0;
                    bus.alu_out_valid = 1'b0;
                    tick(4);
                    chk("r_junk_nwr", 32'(wr_q.size()), 32'd0);
                    chk("r_junk_npush", 32'(push_q.size()), 32'd0);
                end
            endcase
        end

        chk("single_cycle_pulses", 32'(dbl), 32'd0);
        chk("push_while_full", 32'(full_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
